// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus: the LSU (master) raises req until gnt, then waits for a single rvalid response.
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage: sized loads/stores over a req/gnt/rvalid bus with misalignment and watchdog errors,
// a combinational upstream stall, and the resolved next-PC (condpc) back to fetch.
module mem_stage_lsu #(
  parameter int XLEN         = 32,
  parameter int TIMEOUT_CYC  = 64,
  parameter bit JALR_CLR_LSB = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_npc,
  mem_stage_lsu_if.master dmem,
  output logic            stall,
  output logic [XLEN-1:0] condpc,
  output logic            take_branch,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_lmd,
  output logic            misaligned_exc,
  output logic            bus_err,
  output logic [XLEN-1:0] exc_addr
);
  localparam int NB  = XLEN / 8;
  localparam int LW  = $clog2(NB);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d, we_q, we_d, ld_q, ld_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, vaddr_q, vaddr_d;
  logic [NB-1:0]   be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            wb_valid_q, wb_valid_d, mis_q, mis_d, berr_q, berr_d;
  logic [XLEN-1:0] lmd_q, lmd_d, exc_q, exc_d;

  logic            is_load, is_mem, misal, timeout;
  logic [LW-1:0]   lane;
  logic [NB-1:0]   st_be;
  logic [XLEN-1:0] st_wdata, ld_shift, ld_data;

  // Access decode, alignment and store lane placement from the execute-stage operands.
  always_comb begin
    is_load = (ex_opcode == OP_LOAD);
    is_mem  = ex_valid && (is_load || ex_opcode == OP_STORE);
    lane    = ex_alu_result[LW-1:0];
    misal   = 1'b0;
    case (ex_funct3[1:0])
      2'd1:    misal = ex_alu_result[0];
      2'd2:    misal = |ex_alu_result[1:0];
      2'd3:    misal = (XLEN == 32) || (|ex_alu_result[2:0]);
      default: misal = 1'b0;
    endcase
    if (ex_funct3 == 3'b111 || (XLEN == 32 && ex_funct3 == 3'b110)) misal = 1'b1;

    st_be    = '0;
    st_wdata = '0;
    case (ex_funct3[1:0])
      2'd0: begin
        st_be    = NB'(1) << lane;
        st_wdata = {NB{ex_rs2_data[7:0]}};
      end
      2'd1: begin
        st_be    = NB'(2'b11) << lane;
        st_wdata = {(NB/2){ex_rs2_data[15:0]}};
      end
      2'd2: begin
        st_be    = NB'(4'hF) << lane;
        st_wdata = {(NB/4){ex_rs2_data[31:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = ex_rs2_data;
      end
    endcase
  end

  // Load data comes back on the full bus word; shift the addressed lane down before extending.
  always_comb begin
    ld_shift = dmem.rdata >> {vaddr_q[LW-1:0], 3'b000};
    ld_data  = ld_shift;
    case (f3_q[1:0])
      2'd0:    ld_data = f3_q[2] ? XLEN'(ld_shift[7:0])  : XLEN'($signed(ld_shift[7:0]));
      2'd1:    ld_data = f3_q[2] ? XLEN'(ld_shift[15:0]) : XLEN'($signed(ld_shift[15:0]));
      2'd2:    ld_data = f3_q[2] ? XLEN'(ld_shift[31:0]) : XLEN'($signed(ld_shift[31:0]));
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    condpc      = ex_npc;
    take_branch = 1'b0;
    if (ex_valid) begin
      case (ex_opcode)
        OP_BRANCH: if (ex_zero) begin
          condpc      = ex_alu_result;
          take_branch = 1'b1;
        end
        OP_JAL: begin
          condpc      = ex_alu_result;
          take_branch = 1'b1;
        end
        OP_JALR: begin
          condpc = ex_alu_result;
          if (JALR_CLR_LSB) condpc[0] = 1'b0;
          take_branch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // >= rather than == so a gnt landing on the last REQ cycle still times out in WAIT.
  assign timeout = (state_q != IDLE) && (wdog_q >= WDW'(TIMEOUT_CYC - 1));
  assign stall   = (state_q == IDLE && is_mem && !misal) || (state_q == REQ) ||
                   (state_q == WAIT && !dmem.rvalid && !timeout);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    vaddr_d    = vaddr_q;
    f3_d       = f3_q;
    ld_d       = ld_q;
    wdog_d     = '0;
    wb_valid_d = 1'b0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    lmd_d      = lmd_q;
    exc_d      = exc_q;
    case (state_q)
      IDLE: begin
        if (is_mem && misal) begin
          wb_valid_d = 1'b1;
          mis_d      = 1'b1;
          exc_d      = ex_alu_result;
        end else if (is_mem) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = !is_load;
          addr_d  = {ex_alu_result[XLEN-1:LW], LW'(0)};
          be_d    = st_be;
          wdata_d = st_wdata;
          vaddr_d = ex_alu_result;
          f3_d    = ex_funct3;
          ld_d    = is_load;
        end else if (ex_valid) begin
          wb_valid_d = 1'b1;
          if (ex_opcode == OP_JAL || ex_opcode == OP_JALR) lmd_d = ex_npc;
        end
      end
      REQ, WAIT: begin
        if (state_q == REQ && dmem.gnt) begin
          req_d   = 1'b0;
          state_d = WAIT;
          wdog_d  = wdog_q + WDW'(1);
        end else if (state_q == WAIT && dmem.rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          if (ld_q) lmd_d = ld_data;
        end else if (timeout) begin
          req_d      = 1'b0;
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          berr_d     = 1'b1;
          exc_d      = vaddr_q;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      ld_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      vaddr_q    <= '0;
      f3_q       <= '0;
      wdog_q     <= '0;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      lmd_q      <= '0;
      exc_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      ld_q       <= ld_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      vaddr_q    <= vaddr_d;
      f3_q       <= f3_d;
      wdog_q     <= wdog_d;
      wb_valid_q <= wb_valid_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
      lmd_q      <= lmd_d;
      exc_q      <= exc_d;
    end
  end

  assign dmem.req       = req_q;
  assign dmem.we        = we_q;
  assign dmem.addr      = addr_q;
  assign dmem.be        = be_q;
  assign dmem.wdata     = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_lmd         = lmd_q;
  assign misaligned_exc = mis_q;
  assign bus_err        = berr_q;
  assign exc_addr       = exc_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed scenarios then random ops against a byte-level reference model.
module tb_mem_stage_lsu;
  localparam int XLEN = 32;
  localparam int TO   = 8;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_zero;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_rs2_data, ex_npc;
  logic        stall, take_branch, wb_valid, misaligned_exc, bus_err;
  logic [31:0] condpc, wb_lmd, exc_addr;

  mem_stage_lsu_if #(.XLEN(XLEN)) dmem();

  mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT_CYC(TO), .JALR_CLR_LSB(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_zero(ex_zero), .ex_npc(ex_npc),
    .dmem(dmem), .stall(stall), .condpc(condpc), .take_branch(take_branch), .wb_valid(wb_valid),
    .wb_lmd(wb_lmd), .misaligned_exc(misaligned_exc), .bus_err(bus_err), .exc_addr(exc_addr));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] lmd; logic mis; logic berr; logic [31:0] eaddr; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } rq_t;

  wb_t exp_wb[$];
  rq_t exp_rq[$];
  int  vectors = 0, miscompares = 0;
  int  g_cnt = 0, rv_dly = 1, rv_cnt = 0;
  bit  hang = 1'b0;
  logic [31:0] rd_val = '0, mdl_lmd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference model: byte-by-byte view of the access, independent of any shifter structure.
  function automatic bit mdl_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    if (f3 == 3'b111 || f3 == 3'b110 || f3[1:0] == 2'd3) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n, lane;
    logic [63:0] v, ones;
    n = 1 << f3[1:0];
    lane = int'(a % 4);
    v = '0;
    ones = '1;
    for (int i = 0; i < n; i++) v |= 64'((rd >> (8 * (lane + i))) & 32'hFF) << (8 * i);
    if (!f3[2] && v[8 * n - 1]) v |= ones << (8 * n);
    return v[31:0];
  endfunction

  function automatic logic [3:0] mdl_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] b;
    int n;
    n = 1 << f3[1:0];
    b = '0;
    for (int i = 0; i < n; i++) b |= 4'(1 << (int'(a % 4) + i));
    return b;
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int n;
    n = 1 << f3[1:0];
    w = '0;
    for (int j = 0; j < 4; j++) w |= ((rs2 >> (8 * (j % n))) & 32'hFF) << (8 * j);
    return w;
  endfunction

  // Memory responder: grants after g_cnt REQ cycles, answers rv_dly cycles after the grant.
  initial begin
    rq_t r;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    forever begin
      @(posedge clk); #1;
      dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin dmem.rvalid = 1'b1; dmem.rdata = rd_val; end
      end else if (dmem.req === 1'b1 && !hang) begin
        if (g_cnt > 0) g_cnt--;
        else begin
          dmem.gnt = 1'b1;
          rv_cnt = rv_dly;
          if (exp_rq.size() == 0) fail_now("unexpected_dmem_req");
          else begin
            r = exp_rq.pop_front();
            chk("dmem_we", 64'(dmem.we), 64'(r.we));
            chk("dmem_addr", 64'(dmem.addr), 64'(r.addr));
            chk("dmem_be", 64'(dmem.be), 64'(r.be));
            if (r.we) chk("dmem_wdata", 64'(dmem.wdata), 64'(r.wdata));
          end
        end
      end
    end
  end

  // Writeback monitor: every wb_valid pulse consumes one scoreboard entry.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (exp_wb.size() == 0) fail_now("unexpected_wb_valid");
        else begin
          e = exp_wb.pop_front();
          chk("wb_lmd", 64'(wb_lmd), 64'(e.lmd));
          chk("misaligned_exc", 64'(misaligned_exc), 64'(e.mis));
          chk("bus_err", 64'(bus_err), 64'(e.berr));
          if (e.mis || e.berr) chk("exc_addr", 64'(exc_addr), 64'(e.eaddr));
        end
      end
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2,
                       input logic z, input logic [31:0] npc, input logic [31:0] rd,
                       input int gd, input int rdl, input bit hg);
    bit mem, mis, xtb;
    int exp_st, st, n;
    logic [31:0] xpc;
    wb_t w;
    rq_t r;
    mem = (op == OP_LOAD || op == OP_STORE);
    mis = mem && mdl_misaligned(f3, a);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3; ex_alu_result = a;
    ex_rs2_data = rs2; ex_zero = z; ex_npc = npc;
    g_cnt = gd; rv_dly = rdl; hang = hg; rd_val = rd;
    xpc = npc; xtb = 1'b0;
    if ((op == OP_BRANCH && z) || op == OP_JAL) begin xpc = a; xtb = 1'b1; end
    else if (op == OP_JALR) begin xpc = a & ~32'h1; xtb = 1'b1; end
    w.lmd = mdl_lmd; w.mis = 1'b0; w.berr = 1'b0; w.eaddr = '0;
    exp_st = 0;
    if (mis) begin
      w.mis = 1'b1; w.eaddr = a;
    end else if (mem && hg) begin
      w.berr = 1'b1; w.eaddr = a; exp_st = 1 + TO;
    end else if (mem) begin
      r.we = (op == OP_STORE); r.addr = a - (a % 4); r.be = mdl_be(f3, a); r.wdata = mdl_wdata(f3, rs2);
      exp_rq.push_back(r);
      if (op == OP_LOAD) begin mdl_lmd = mdl_load(f3, a, rd); w.lmd = mdl_lmd; end
      exp_st = gd + rdl + 1;
    end else if (op == OP_JAL || op == OP_JALR) begin
      mdl_lmd = npc; w.lmd = npc;
    end
    exp_wb.push_back(w);
    @(negedge clk);
    chk("condpc", 64'(condpc), 64'(xpc));
    chk("take_branch", 64'(take_branch), 64'(xtb));
    st = (stall === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      st++; n++;
    end
    if (n >= 200) fail_now("stall_never_released");
    chk("stall_cycles", 64'(st), 64'(exp_st));
    if (!mem || mis || hg) chk("dmem_req_low", 64'(dmem.req), 64'd0);
    @(posedge clk); @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin
    rq_t rr;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] a;
    int k;
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0; ex_alu_result = '0;
    ex_rs2_data = '0; ex_zero = 1'b0; ex_npc = '0;
    #2;
    chk("rst_req", 64'(dmem.req), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_be", 64'(dmem.be), 64'd0);
    chk("rst_wb_lmd", 64'(wb_lmd), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(OP_LOAD,  3'b000, 32'h103, 32'h0,    1'b0, 32'h1004, 32'h80FF_1234, 0, 2, 1'b0);
    issue(OP_STORE, 3'b001, 32'h202, 32'h0000_ABCD, 1'b0, 32'h1008, 32'h0, 1, 1, 1'b0);
    issue(OP_LOAD,  3'b010, 32'h301, 32'h0,    1'b0, 32'h100C, 32'h0, 0, 1, 1'b0);
    issue(OP_LOAD,  3'b101, 32'h0,   32'h0,    1'b0, 32'h1010, 32'h0, 0, 1, 1'b1);
    issue(OP_LOAD,  3'b100, 32'h2,   32'h0,    1'b0, 32'h1014, 32'h1234_5678, 0, 1, 1'b0);
    issue(OP_BRANCH,3'b000, 32'h400, 32'h0,    1'b1, 32'h20,   32'h0, 0, 1, 1'b0);
    issue(OP_JALR,  3'b000, 32'h501, 32'h0,    1'b0, 32'h24,   32'h0, 0, 1, 1'b0);

    // Reset in WAIT; the pending response then arrives while IDLE and must be ignored.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_funct3 = 3'b010; ex_alu_result = 32'h600;
    g_cnt = 0; rv_dly = 6; hang = 1'b0; rd_val = 32'hDEAD_BEEF;
    rr.we = 1'b0; rr.addr = 32'h600; rr.be = 4'hF; rr.wdata = '0;
    exp_rq.push_back(rr);
    @(posedge clk); #1 ex_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("stall_in_wait", 64'(stall), 64'd1);
    rst = 1'b1; #1;
    chk("arst_req", 64'(dmem.req), 64'd0);
    chk("arst_addr", 64'(dmem.addr), 64'd0);
    chk("arst_be", 64'(dmem.be), 64'd0);
    chk("arst_wdata", 64'(dmem.wdata), 64'd0);
    chk("arst_wb_lmd", 64'(wb_lmd), 64'd0);
    chk("arst_exc_addr", 64'(exc_addr), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    mdl_lmd = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    ex_opcode = OP_JAL; ex_alu_result = 32'h99; ex_npc = 32'h77; #1;
    chk("idle_condpc", 64'(condpc), 64'h77);
    chk("idle_take_branch", 64'(take_branch), 64'd0);

    issue(OP_JAL,    3'b000, 32'h800, 32'h0, 1'b0, 32'h30, 32'h0, 0, 1, 1'b0);
    issue(OP_ALU,    3'b000, 32'h5,   32'h0, 1'b0, 32'h34, 32'h0, 0, 1, 1'b0);
    issue(OP_BRANCH, 3'b000, 32'h900, 32'h0, 1'b0, 32'h38, 32'h0, 0, 1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1: begin op = OP_LOAD;  f3 = 3'($urandom_range(0, 6)); end
        2:    begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
        3:    begin op = OP_BRANCH; f3 = 3'($urandom_range(0, 7)); end
        4:    begin op = ($urandom_range(0, 1) == 1) ? OP_JAL : OP_JALR; f3 = 3'b000; end
        default: begin op = OP_ALU; f3 = 3'($urandom_range(0, 7)); end
      endcase
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      issue(op, f3, a, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(1, 3), ($urandom_range(0, 9) == 0));
    end

    repeat (4) @(posedge clk);
    chk("wb_queue_drained", 64'(exp_wb.size()), 64'd0);
    chk("req_queue_drained", 64'(exp_rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
